// File: rtl/uninasoc_pkg.sv
// Shared SoC package: interrupt line map and PLIC gateway types.
package uninasoc_pkg;

  // PLIC source lines driven by the peripheral bus (line 0 is reserved)
  localparam int PLIC_GPIOIN_INTERRUPT = 1;
  localparam int PLIC_TIM0_INTERRUPT   = 2;
  localparam int PLIC_TIM1_INTERRUPT   = 3;
  localparam int PLIC_UART_INTERRUPT   = 4;

  // Interrupt indices as they appear on the peripheral bus
  localparam int PBUS_GPIOIN_INTR_IDX  = 0;
  localparam int PBUS_TIM0_INTR_IDX    = 1;
  localparam int PBUS_TIM1_INTR_IDX    = 2;
  localparam int PBUS_UART_INTR_IDX    = 3;

  localparam int PLIC_NUM_SOURCES = 32;
  localparam int PLIC_ID_W        = 5;

  typedef enum logic [1:0] {
    GW_IDLE     = 2'd0,
    GW_PENDING  = 2'd1,
    GW_INFLIGHT = 2'd2
  } plic_gw_state_t;

  // PBUS index feeding a given PLIC line, or -1 when the line is unmapped
  function automatic int plic_gw_pbus_of_line(input int line);
    case (line)
      PLIC_GPIOIN_INTERRUPT: return PBUS_GPIOIN_INTR_IDX;
      PLIC_TIM0_INTERRUPT:   return PBUS_TIM0_INTR_IDX;
      PLIC_TIM1_INTERRUPT:   return PBUS_TIM1_INTR_IDX;
      PLIC_UART_INTERRUPT:   return PBUS_UART_INTR_IDX;
      default:               return -1;
    endcase
  endfunction

endpackage

// File: rtl/plic_gateway_cell.sv
// One PLIC gateway source: synchroniser, optional edge detector and
// missed-edge counter, and the IDLE/PENDING/INFLIGHT request FSM.
// Edge support is built only when PLIC_GATEWAY_EDGE_EN is defined.
module plic_gateway_cell
  import uninasoc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_CNT_W  = 3
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic intr_i,
  input  logic edge_cfg_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  plic_gw_state_t         r_state, w_state_nxt;
  logic                   r_pend;
  logic                   w_req;
  logic                   w_use_cnt;
  logic                   w_level_drop;

  // Synchroniser chain for the raw asynchronous interrupt
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) r_sync <= '0;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], intr_i};
  end

`ifdef PLIC_GATEWAY_EDGE_EN
  logic                  r_sync_q, r_sync_prev_q, r_edge_mode;
  logic [EDGE_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic                  w_rise, w_inc;

  // Edge-detect pair and the mode actually in force (one cycle behind cfg)
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_sync_q      <= 1'b0;
      r_sync_prev_q <= 1'b0;
      r_edge_mode   <= 1'b0;
    end else begin
      r_sync_q      <= r_sync[SYNC_STAGES-1];
      r_sync_prev_q <= r_sync_q;
      r_edge_mode   <= edge_cfg_i;
    end
  end

  assign w_rise       = r_sync_q & ~r_sync_prev_q;
  assign w_req        = r_edge_mode ? w_rise : r_sync_q;
  assign w_level_drop = ~r_edge_mode & ~r_sync_q;
  // A completed source with banked edges re-pends from IDLE, which is what
  // makes the re-pend appear two cycles after the completion.
  assign w_use_cnt    = r_edge_mode & (r_state == GW_IDLE) & (r_cnt != '0);
  // An edge while IDLE with nothing banked is consumed directly as the request
  assign w_inc        = w_rise & ((r_state != GW_IDLE) | w_use_cnt);

  // Missed-edge counter: saturating increment, decrement on re-pend
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (edge_cfg_i != r_edge_mode) begin
      w_cnt_nxt = '0;
    end else if (r_edge_mode) begin
      if (w_inc && !w_use_cnt) begin
        if (r_cnt != {EDGE_CNT_W{1'b1}}) w_cnt_nxt = r_cnt + 1'b1;
      end else if (!w_inc && w_use_cnt) begin
        w_cnt_nxt = r_cnt - 1'b1;
      end
    end
  end

  // Counter register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) r_cnt <= '0;
    else         r_cnt <= w_cnt_nxt;
  end
`else
  logic w_unused_cfg;
  localparam int lp_unused_cnt_w = EDGE_CNT_W;

  assign w_unused_cfg = edge_cfg_i;
  assign w_req        = r_sync[SYNC_STAGES-1];
  assign w_level_drop = ~r_sync[SYNC_STAGES-1];
  assign w_use_cnt    = 1'b0;
`endif

  // Request FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      GW_IDLE:     if (w_req || w_use_cnt) w_state_nxt = GW_PENDING;
      GW_PENDING: begin
        if (claim_i)           w_state_nxt = GW_INFLIGHT;
        else if (w_level_drop) w_state_nxt = GW_IDLE;
      end
      GW_INFLIGHT: if (complete_i) w_state_nxt = GW_IDLE;
      default:     w_state_nxt = GW_IDLE;
    endcase
  end

  // State register; pending flag registered alongside so it tracks the state
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= GW_IDLE;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= (w_state_nxt == GW_PENDING);
    end
  end

  assign pending_o = r_pend;

endmodule

// File: rtl/plic_gateway.sv
// PLIC interrupt gateway: maps PBUS interrupts onto PLIC lines 1..N-1 and
// runs one gateway cell per line. Define PLIC_GATEWAY_EDGE_EN to enable
// edge-triggered sources and missed-edge counting.
module plic_gateway
  import uninasoc_pkg::*;
#(
  parameter int NUM_SOURCES   = PLIC_NUM_SOURCES,
  parameter int PBUS_NUM_INTR = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int EDGE_CNT_W    = 3
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [PBUS_NUM_INTR-1:0] pbus_intr_i,
  input  logic [NUM_SOURCES-1:0]   edge_cfg_i,
  input  logic                     claim_valid_i,
  input  logic [PLIC_ID_W-1:0]     claim_id_i,
  input  logic                     complete_valid_i,
  input  logic [PLIC_ID_W-1:0]     complete_id_i,
  output logic [NUM_SOURCES-1:0]   irq_pending_o
);

  logic w_unused_cfg0;

  // Line 0 is reserved: never pending, its config bit has no meaning
  assign w_unused_cfg0    = edge_cfg_i[0];
  assign irq_pending_o[0] = 1'b0;

  for (genvar i = 1; i < NUM_SOURCES; i++) begin : g_src
    localparam int                   K  = plic_gw_pbus_of_line(i);
    localparam logic [PLIC_ID_W-1:0] ID = PLIC_ID_W'(i);
    logic w_intr, w_claim, w_complete;

    if (K >= 0 && K < PBUS_NUM_INTR) begin : g_map
      assign w_intr = pbus_intr_i[K];
    end else begin : g_nomap
      assign w_intr = 1'b0;
    end

    // Id 0 and ids beyond the last line never match any cell
    assign w_claim    = claim_valid_i    & (claim_id_i    == ID);
    assign w_complete = complete_valid_i & (complete_id_i == ID);

    plic_gateway_cell #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_CNT_W  (EDGE_CNT_W)
    ) u_cell (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .intr_i     (w_intr),
      .edge_cfg_i (edge_cfg_i[i]),
      .claim_i    (w_claim),
      .complete_i (w_complete),
      .pending_o  (irq_pending_o[i])
    );
  end

endmodule
